// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scroll controller: character codes,
// font patterns (bit13..0 = a,b,c,d,e,f,g1,g2,h,i,j,k,l,m) and scan state type.
package seg14_pkg;

    localparam int NUM_DIGITS_DEF = 12;

    typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;

    localparam logic [5:0] CH_A = 6'd0,  CH_B = 6'd1,  CH_C = 6'd2,  CH_D = 6'd3;
    localparam logic [5:0] CH_E = 6'd4,  CH_F = 6'd5,  CH_G = 6'd6,  CH_H = 6'd7;
    localparam logic [5:0] CH_I = 6'd8,  CH_J = 6'd9,  CH_K = 6'd10, CH_L = 6'd11;
    localparam logic [5:0] CH_M = 6'd12, CH_N = 6'd13, CH_O = 6'd14, CH_P = 6'd15;
    localparam logic [5:0] CH_Q = 6'd16, CH_R = 6'd17, CH_S = 6'd18, CH_T = 6'd19;
    localparam logic [5:0] CH_U = 6'd20, CH_V = 6'd21, CH_W = 6'd22, CH_X = 6'd23;
    localparam logic [5:0] CH_Y = 6'd24, CH_Z = 6'd25;
    localparam logic [5:0] CH_0 = 6'd26, CH_1 = 6'd27, CH_2 = 6'd28, CH_3 = 6'd29;
    localparam logic [5:0] CH_4 = 6'd30, CH_5 = 6'd31, CH_6 = 6'd32, CH_7 = 6'd33;
    localparam logic [5:0] CH_8 = 6'd34, CH_9 = 6'd35;
    localparam logic [5:0] CH_NN = 6'd36, CH_SPACE = 6'd63;

    localparam logic [13:0] F_A = 14'b11101111000000, F_B = 14'b11110001010010;
    localparam logic [13:0] F_C = 14'b10011100000000, F_D = 14'b11110000010010;
    localparam logic [13:0] F_E = 14'b10011110000000, F_F = 14'b10001110000000;
    localparam logic [13:0] F_G = 14'b10111101000000, F_H = 14'b01101111000000;
    localparam logic [13:0] F_I = 14'b10010000010010, F_J = 14'b01111000000000;
    localparam logic [13:0] F_K = 14'b00001110001100, F_L = 14'b00011100000000;
    localparam logic [13:0] F_M = 14'b01101100101000, F_N = 14'b01101100100100;
    localparam logic [13:0] F_O = 14'b11111100000000, F_P = 14'b11001111000000;
    localparam logic [13:0] F_Q = 14'b11111100000100, F_R = 14'b11001111000100;
    localparam logic [13:0] F_S = 14'b10110111000000, F_T = 14'b10000000010010;
    localparam logic [13:0] F_U = 14'b01111100000000, F_V = 14'b00001100001001;
    localparam logic [13:0] F_W = 14'b01101100000101, F_X = 14'b00000000101101;
    localparam logic [13:0] F_Y = 14'b00000000101010, F_Z = 14'b10010000001001;
    localparam logic [13:0] F_0 = 14'b11111100001001, F_1 = 14'b01100000001000;
    localparam logic [13:0] F_2 = 14'b11011011000000, F_3 = 14'b11110011000000;
    localparam logic [13:0] F_4 = 14'b01100111000000, F_5 = 14'b10110111000000;
    localparam logic [13:0] F_6 = 14'b10111111000000, F_7 = 14'b11100000000000;
    localparam logic [13:0] F_8 = 14'b11111111000000, F_9 = 14'b11110111000000;
    localparam logic [13:0] F_NN = 14'b11101100100100;

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment pattern ROM.
// Space and all unassigned codes decode to a dark digit.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [5:0]  code,
    output logic [13:0] pattern
);

    always_comb begin
        pattern = 14'b0;
        case (code)
            CH_A: pattern = F_A;   CH_B: pattern = F_B;   CH_C: pattern = F_C;
            CH_D: pattern = F_D;   CH_E: pattern = F_E;   CH_F: pattern = F_F;
            CH_G: pattern = F_G;   CH_H: pattern = F_H;   CH_I: pattern = F_I;
            CH_J: pattern = F_J;   CH_K: pattern = F_K;   CH_L: pattern = F_L;
            CH_M: pattern = F_M;   CH_N: pattern = F_N;   CH_O: pattern = F_O;
            CH_P: pattern = F_P;   CH_Q: pattern = F_Q;   CH_R: pattern = F_R;
            CH_S: pattern = F_S;   CH_T: pattern = F_T;   CH_U: pattern = F_U;
            CH_V: pattern = F_V;   CH_W: pattern = F_W;   CH_X: pattern = F_X;
            CH_Y: pattern = F_Y;   CH_Z: pattern = F_Z;
            CH_0: pattern = F_0;   CH_1: pattern = F_1;   CH_2: pattern = F_2;
            CH_3: pattern = F_3;   CH_4: pattern = F_4;   CH_5: pattern = F_5;
            CH_6: pattern = F_6;   CH_7: pattern = F_7;   CH_8: pattern = F_8;
            CH_9: pattern = F_9;   CH_NN: pattern = F_NN;
            default: pattern = 14'b0;
        endcase
    end

endmodule

// File: rtl/seg14_scroll_ctrl.sv
// Scan/scroll controller: writable message buffer, font decode and blanked
// one-digit-at-a-time multiplexing with optional left scroll per N frames.
module seg14_scroll_ctrl
    import seg14_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
    parameter int MSG_DEPTH     = 32,
    parameter int REFRESH_DIV   = 16,
    parameter int BLANK_CYC     = 2,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [5:0]            wr_char,
    input  logic [5:0]            msg_len,
    input  logic                  scroll_en,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [13:0]           segm,
    output logic                  frame_done
);

    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FC_W    = $clog2(SCROLL_FRAMES + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DRIVE_PRE  = CNT_W'((REFRESH_DIV > 1) ? REFRESH_DIV - 2 : 0);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(SCROLL_FRAMES - 1);
    localparam logic [5:0]       DEPTH6     = 6'(MSG_DEPTH);

    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [DIG_W-1:0] digit_reg;
    logic [4:0]       ptr_reg;
    logic [4:0]       offset_reg;
    logic [5:0]       len_reg;
    logic [FC_W-1:0]  fc_reg;
    logic [5:0]       msg_mem [MSG_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < MSG_DEPTH; gi++) begin : g_buf
            logic [5:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= CH_SPACE;
                else if (wr_en && wr_addr == 5'(gi))
                    entry_reg <= wr_char;
            end
            assign msg_mem[gi] = entry_reg;
        end
    endgenerate

    // Digit 0 starts a frame: length and scroll offset are (re)sampled there.
    logic       first_digit;
    logic [5:0] len_sat;
    logic [4:0] offset_start;
    logic [4:0] ptr_inc;
    logic [4:0] rd_idx;
    logic [5:0] rd_len;
    logic [13:0] font_pat;
    logic       frame_pre;

    assign first_digit  = (digit_reg == '0);
    assign len_sat      = (msg_len > DEPTH6) ? DEPTH6 : msg_len;
    assign offset_start = ({1'b0, offset_reg} >= len_sat) ? 5'd0 : offset_reg;
    assign ptr_inc      = ({1'b0, ptr_reg} + 6'd1 == len_reg) ? 5'd0 : ptr_reg + 5'd1;
    assign rd_idx       = first_digit ? offset_start : ptr_inc;
    assign rd_len       = first_digit ? len_sat : len_reg;

    // frame_done is registered, so it is raised one cycle ahead of the last DRIVE cycle.
    assign frame_pre = (digit_reg == LAST_DIGIT) &&
                       (((state_reg == ST_BLANK) && (cnt_reg == BLANK_LAST) && (REFRESH_DIV == 1)) ||
                        ((state_reg == ST_DRIVE) && (REFRESH_DIV > 1) && (cnt_reg == DRIVE_PRE)));

    seg14_font u_font (
        .code    (msg_mem[rd_idx]),
        .pattern (font_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_BLANK;
            cnt_reg    <= '0;
            digit_reg  <= '0;
            ptr_reg    <= '0;
            offset_reg <= '0;
            len_reg    <= '0;
            fc_reg     <= '0;
            sel        <= '0;
            segm       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_pre;
            case (state_reg)
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg <= ST_DRIVE;
                        cnt_reg   <= '0;
                        sel       <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_reg;
                        segm      <= (rd_len == 6'd0) ? 14'b0 : font_pat;
                        ptr_reg   <= rd_idx;
                        if (first_digit) begin
                            len_reg    <= len_sat;
                            offset_reg <= offset_start;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_reg == DRIVE_LAST) begin
                        state_reg <= ST_BLANK;
                        cnt_reg   <= '0;
                        sel       <= '0;
                        segm      <= '0;
                        if (digit_reg == LAST_DIGIT) begin
                            digit_reg <= '0;
                            if (scroll_en) begin
                                if (fc_reg == FC_LAST) begin
                                    fc_reg     <= '0;
                                    offset_reg <= ({1'b0, offset_reg} + 6'd1 == len_reg) ?
                                                  5'd0 : offset_reg + 5'd1;
                                end else begin
                                    fc_reg <= fc_reg + FC_W'(1);
                                end
                            end
                        end else begin
                            digit_reg <= digit_reg + DIG_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_BLANK;
            endcase
        end
    end

endmodule
